char_jump_ctrl: RTL and testbench

Sequences one character jump, driven by the periodic movement tick from the movement timer.
- Holding the jump button charges jump power.
- Releasing it launches a rise-then-fall trajectory with horizontal drift and wall bounce.
- The jump ends on a platform hit or the floor.
- Sits between input debouncing / platform collision and the character draw block; xpos/ypos feed the sprite renderer.

---
 rtl/char_jump_ctrl.sv | 136 +++++++++++++
 tb/tb_char_jump_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/char_jump_ctrl.sv
// Character jump sequencer: charge power while the button is held, then rise/fall with
// horizontal drift and wall bounce, stepping once per movement tick until landing.
module char_jump_ctrl #(
    parameter logic [9:0] X_START   = 10'd380,
    parameter logic [9:0] Y_FLOOR   = 10'd550,
    parameter logic [9:0] X_MIN     = 10'd0,
    parameter logic [9:0] X_MAX     = 10'd760,
    parameter logic [5:0] MAX_POWER = 6'd40
) (
    input  logic       clk_40MHz,
    input  logic       rst_n,
    input  logic       movement_tick,
    input  logic       btn_jump,
    input  logic       dir_in,
    input  logic       land_hit,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [1:0] state_out,
    output logic       busy,
    output logic       jump_done
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCharge = 2'd1,
        StRise   = 2'd2,
        StFall   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [5:0] power_q, power_d;
    logic [5:0] rise_q, rise_d;
    logic       dir_q, dir_d;
    logic       done_q, done_d;

    logic [5:0] power_nxt;
    logic [9:0] x_step;
    logic       dir_step;

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= X_START;
            y_q     <= Y_FLOOR;
            power_q <= 6'd0;
            rise_q  <= 6'd0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            power_q <= power_d;
            rise_q  <= rise_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // Horizontal step with bounce: at a wall the direction flips and x holds for that tick.
    always_comb begin
        x_step   = x_q;
        dir_step = dir_q;
        if (dir_q) begin
            if (x_q >= X_MAX) dir_step = 1'b0;
            else              x_step   = x_q + 10'd1;
        end else begin
            if (x_q <= X_MIN) dir_step = 1'b1;
            else              x_step   = x_q - 10'd1;
        end
    end

    assign power_nxt = (movement_tick && (power_q < MAX_POWER)) ? power_q + 6'd1 : power_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        power_d = power_q;
        rise_d  = rise_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_jump) begin
                    state_d = StCharge;
                    power_d = 6'd0;
                    dir_d   = dir_in;
                end
            end
            StCharge: begin
                power_d = power_nxt;
                if (!btn_jump) begin
                    if (power_nxt == 6'd0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRise;
                        rise_d  = power_nxt;
                    end
                end
            end
            StRise: begin
                if (movement_tick) begin
                    y_d    = (y_q == 10'd0) ? 10'd0 : y_q - 10'd1;
                    x_d    = x_step;
                    dir_d  = dir_step;
                    rise_d = rise_q - 6'd1;
                    if (rise_q <= 6'd1) state_d = StFall;
                end
            end
            StFall: begin
                if (movement_tick) begin
                    if (land_hit || (y_q >= Y_FLOOR)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        if (y_q > Y_FLOOR) y_d = Y_FLOOR;
                    end else begin
                        y_d   = (y_q == 10'h3FF) ? y_q : y_q + 10'd1;
                        x_d   = x_step;
                        dir_d = dir_step;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign xpos      = x_q;
    assign ypos      = y_q;
    assign state_out = state_q;
    assign busy      = (state_q == StRise) || (state_q == StFall);
    assign jump_done = done_q;

endmodule

// File: tb/tb_char_jump_ctrl.sv
// Bench for char_jump_ctrl: directed jumps with a landing scoreboard plus wall-bounce instance.
`timescale 1ns/1ps
module tb_char_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       movement_tick, btn_jump, dir_in, land_hit;
    logic [9:0] xpos, ypos, w_xpos, w_ypos;
    logic [1:0] state_out, w_state;
    logic       busy, jump_done, w_busy, w_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        int    x;
        int    y;
    } land_t;
    land_t sb[$];

    always #10 clk = ~clk;

    char_jump_ctrl u_dut (
        .clk_40MHz    (clk),
        .rst_n        (rst_n),
        .movement_tick(movement_tick),
        .btn_jump     (btn_jump),
        .dir_in       (dir_in),
        .land_hit     (land_hit),
        .xpos         (xpos),
        .ypos         (ypos),
        .state_out    (state_out),
        .busy         (busy),
        .jump_done    (jump_done)
    );

    char_jump_ctrl #(.X_START(10'd758)) u_wall (
        .clk_40MHz    (clk),
        .rst_n        (rst_n),
        .movement_tick(movement_tick),
        .btn_jump     (btn_jump),
        .dir_in       (dir_in),
        .land_hit     (land_hit),
        .xpos         (w_xpos),
        .ypos         (w_ypos),
        .state_out    (w_state),
        .busy         (w_busy),
        .jump_done    (w_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive tick for the coming edge, return at the next falling edge.
    task automatic cyc(input logic t);
        movement_tick = t;
        @(negedge clk);
        movement_tick = 1'b0;
    endtask

    task automatic push_land(input string name, input int x, input int y);
        land_t e;
        e.name = name;
        e.x    = x;
        e.y    = y;
        sb.push_back(e);
    endtask

    // Landing monitor: every jump_done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n && jump_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_jump_done: got 1 expected 0 at x=%0d y=%0d", xpos, ypos);
            end else begin
                land_t e;
                e = sb.pop_front();
                chk({e.name, "_land_x"}, int'(xpos), e.x);
                chk({e.name, "_land_y"}, int'(ypos), e.y);
                chk({e.name, "_land_state"}, int'(state_out), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wall_x[10];
        wall_x = '{759, 760, 760, 759, 758, 757, 756, 755, 754, 753};
        rst_n = 1'b0; movement_tick = 1'b0; btn_jump = 1'b0; dir_in = 1'b0; land_hit = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(xpos), 380);
        chk("rst_y", int'(ypos), 550);
        chk("rst_state", int'(state_out), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        cyc(1'b1);
        chk("idle_tick_no_move_x", int'(xpos), 380);

        // Short jump to the right, 5 ticks of charge; wall instance checks bounce.
        btn_jump = 1'b1; dir_in = 1'b1;
        cyc(1'b0);
        chk("short_charge_state", int'(state_out), 1);
        repeat (5) cyc(1'b1);
        btn_jump = 1'b0; dir_in = 1'b0;
        cyc(1'b0);
        chk("short_rise_state", int'(state_out), 2);
        chk("short_rise_busy", int'(busy), 1);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1);
            chk("short_x", int'(xpos), 380 + i);
            chk("short_y", int'(ypos), (i <= 5) ? 550 - i : 540 + i);
            chk("short_state", int'(state_out), (i < 5) ? 2 : 3);
            chk("wall_x", int'(w_xpos), wall_x[i-1]);
        end
        push_land("short", 390, 550);
        cyc(1'b1);
        chk("short_idle_busy", int'(busy), 0);
        cyc(1'b0);
        chk("short_done_one_cycle", int'(jump_done), 0);

        // Zero charge: press and release with no tick.
        btn_jump = 1'b1;
        cyc(1'b0);
        btn_jump = 1'b0;
        cyc(1'b0);
        chk("zero_state", int'(state_out), 0);
        cyc(1'b1);
        chk("zero_x", int'(xpos), 390);
        chk("zero_y", int'(ypos), 550);

        // Leftward jump: land_hit ignored in RISE, then platform landing at y=520.
        btn_jump = 1'b1; dir_in = 1'b0;
        cyc(1'b0);
        repeat (30) cyc(1'b1);
        btn_jump = 1'b0;
        cyc(1'b0);
        land_hit = 1'b1;
        repeat (30) cyc(1'b1);
        chk("plat_apex_y", int'(ypos), 520);
        chk("plat_apex_x", int'(xpos), 360);
        chk("plat_fall_state", int'(state_out), 3);
        cyc(1'b0);
        chk("plat_no_tick_state", int'(state_out), 3);
        push_land("plat", 360, 520);
        cyc(1'b1);
        land_hit = 1'b0;
        chk("plat_y_kept", int'(ypos), 520);

        // Reset asserted mid-FALL.
        btn_jump = 1'b1; dir_in = 1'b1;
        cyc(1'b0);
        repeat (2) cyc(1'b1);
        btn_jump = 1'b0;
        cyc(1'b0);
        repeat (3) cyc(1'b1);
        chk("mid_fall_state", int'(state_out), 3);
        chk("mid_fall_y", int'(ypos), 519);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_x", int'(xpos), 380);
        chk("async_rst_y", int'(ypos), 550);
        chk("async_rst_state", int'(state_out), 0);
        chk("async_rst_done", int'(jump_done), 0);
        @(negedge clk);
        repeat (2) cyc(1'b1);
        rst_n = 1'b1;
        cyc(1'b1);
        chk("post_rst_state", int'(state_out), 0);
        chk("post_rst_busy", int'(busy), 0);

        // Saturation: 60 ticks of charge give exactly 40 rise steps.
        btn_jump = 1'b1; dir_in = 1'b1;
        cyc(1'b0);
        repeat (60) cyc(1'b1);
        chk("sat_charge_state", int'(state_out), 1);
        btn_jump = 1'b0;
        cyc(1'b0);
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1);
            chk("sat_rise_state", int'(state_out), (i < 40) ? 2 : 3);
        end
        chk("sat_apex_y", int'(ypos), 510);
        chk("sat_apex_x", int'(xpos), 420);
        repeat (40) cyc(1'b1);
        chk("sat_floor_y", int'(ypos), 550);
        push_land("sat", 460, 550);
        cyc(1'b1);

        repeat (4) cyc(1'b0);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
